// File: rtl/snake_text_pkg.sv
// Shared text-overlay definitions: message tables, message lengths,
// converter state encoding and small constant helpers.
package snake_text_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    COMMIT  = 2'd2
  } conv_state_t;

  localparam int MSG_MAX  = 11;
  localparam int MSG0_LEN = 11;
  localparam int MSG1_LEN = 9;
  localparam int MSG2_LEN = 11;
  localparam int MSG3_LEN = 0;

  // Left-padded with zeros so every message fits the same width.
  localparam logic [8*MSG_MAX-1:0] MSG0_TXT = "YOUR SCORE:";
  localparam logic [8*MSG_MAX-1:0] MSG1_TXT = {16'h0000, "GAME OVER"};
  localparam logic [8*MSG_MAX-1:0] MSG2_TXT = "PRESS START";

  function automatic logic [7:0] msg_char(input logic [1:0] sel, input logic [3:0] col);
    logic [8*MSG_MAX-1:0] txt;
    int                   len;
    int                   idx;
    logic [7:0]           ch;
    case (sel)
      2'd0:    begin txt = MSG0_TXT; len = MSG0_LEN; end
      2'd1:    begin txt = MSG1_TXT; len = MSG1_LEN; end
      2'd2:    begin txt = MSG2_TXT; len = MSG2_LEN; end
      default: begin txt = '0;       len = MSG3_LEN; end
    endcase
    ch = 8'h00;
    if (int'(col) < len) begin
      idx = len - 1 - int'(col);
      ch  = txt[8*idx +: 8];
    end
    // The character generator uses code 0 as the blank glyph.
    if (ch == 8'h20) ch = 8'h00;
    return ch;
  endfunction

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] r;
    r = 64'd1;
    for (int i = 0; i < n; i++) r = r * 64'd10;
    return r;
  endfunction

endpackage

// File: rtl/score_text_gen_if.sv
// Lookup and score-load bundle between the display pipeline and the score text generator.
interface score_text_gen_if #(
  parameter int SCORE_W = 14
);
  logic [7:0]         char_yx;
  logic [1:0]         msg_sel;
  logic [SCORE_W-1:0] score;
  logic               score_load;
  logic [7:0]         char_code;
  logic               busy;

  modport master (
    output char_yx, msg_sel, score, score_load,
    input  char_code, busy
  );

  modport slave (
    input  char_yx, msg_sel, score, score_load,
    output char_code, busy
  );
endinterface

// File: rtl/score_text_gen_bin2bcd_seq.sv
// Sequential binary-to-BCD converter (double dabble, one bit per cycle) with a
// one-deep pending load and a committed digit register that only changes on COMMIT.
module bin2bcd_seq
  import snake_text_pkg::*;
#(
  parameter int SCORE_W    = 14,
  parameter int NUM_DIGITS = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [SCORE_W-1:0]      score,
  input  logic                    score_load,
  output logic                    busy,
  output logic [4*NUM_DIGITS-1:0] digits
);

  localparam int          BCD_W   = 4 * NUM_DIGITS;
  localparam int          CNT_W   = $clog2(SCORE_W + 1);
  localparam logic [63:0] MAX_VAL = pow10(NUM_DIGITS) - 64'd1;

  conv_state_t        state_reg;
  logic [SCORE_W-1:0] bin_reg;
  logic [BCD_W-1:0]   bcd_reg;
  logic [BCD_W-1:0]   bcd_adj;
  logic [BCD_W-1:0]   digits_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic               busy_reg;
  logic               pend_reg;
  logic [SCORE_W-1:0] pend_val_reg;
  logic [SCORE_W-1:0] score_sat;

  // Saturate to all nines so the value always fits the digit field.
  always_comb begin
    score_sat = score;
    if (64'(score) > MAX_VAL) score_sat = SCORE_W'(MAX_VAL);
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_adj
      assign bcd_adj[gi*4 +: 4] = (bcd_reg[gi*4 +: 4] >= 4'd5) ?
                                  bcd_reg[gi*4 +: 4] + 4'd3 : bcd_reg[gi*4 +: 4];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      bin_reg      <= '0;
      bcd_reg      <= '0;
      digits_reg   <= '0;
      cnt_reg      <= '0;
      busy_reg     <= 1'b0;
      pend_reg     <= 1'b0;
      pend_val_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (score_load || pend_reg) begin
            bin_reg   <= score_load ? score_sat : pend_val_reg;
            bcd_reg   <= '0;
            cnt_reg   <= '0;
            pend_reg  <= 1'b0;
            busy_reg  <= 1'b1;
            state_reg <= CONVERT;
          end
        end
        CONVERT: begin
          {bcd_reg, bin_reg} <= {bcd_adj, bin_reg} << 1;
          cnt_reg            <= cnt_reg + 1'b1;
          if (cnt_reg == CNT_W'(SCORE_W - 1)) state_reg <= COMMIT;
        end
        COMMIT: begin
          digits_reg <= bcd_reg;
          busy_reg   <= 1'b0;
          state_reg  <= IDLE;
        end
        default: begin
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
      // Loads arriving while busy (COMMIT included) park here; the latest one wins.
      if (state_reg != IDLE && score_load) begin
        pend_reg     <= 1'b1;
        pend_val_reg <= score_sat;
      end
    end
  end

  assign busy   = busy_reg;
  assign digits = digits_reg;

endmodule

// File: rtl/score_text_gen.sv
// Character lookup for the score/status text overlay: one registered ASCII code
// per char_yx lookup, with the score field fed from the committed BCD digits.
module score_text_gen
  import snake_text_pkg::*;
#(
  parameter int         SCORE_W    = 14,
  parameter int         NUM_DIGITS = 4,
  parameter logic [7:0] DIGIT_COL  = 8'h0C,
  parameter bit         LZ_BLANK   = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  score_text_gen_if.slave  bus
);

  logic [4*NUM_DIGITS-1:0] digits;
  logic                    conv_busy;
  logic [NUM_DIGITS-1:0]   hit;
  logic [7:0]              dig_char [NUM_DIGITS];
  logic [7:0]              char_next;
  logic [7:0]              char_code_reg;

  bin2bcd_seq #(
    .SCORE_W    (SCORE_W),
    .NUM_DIGITS (NUM_DIGITS)
  ) u_conv (
    .clk        (clk),
    .rst        (rst),
    .score      (bus.score),
    .score_load (bus.score_load),
    .busy       (conv_busy),
    .digits     (digits)
  );

  // Digit gi is the gi-th most significant digit, shown at column DIGIT_COL+gi.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      assign hit[gi] = ({4'h0, bus.char_yx[3:0]} == 8'(int'(DIGIT_COL) + gi));
      if (LZ_BLANK && gi < NUM_DIGITS - 1) begin : g_blank
        assign dig_char[gi] = (digits[4*NUM_DIGITS-1 -: 4*(gi+1)] == '0) ? 8'h00 :
                              {4'h3, digits[(NUM_DIGITS-1-gi)*4 +: 4]};
      end else begin : g_plain
        assign dig_char[gi] = {4'h3, digits[(NUM_DIGITS-1-gi)*4 +: 4]};
      end
    end
  endgenerate

  always_comb begin
    char_next = 8'h00;
    if (bus.char_yx[7:4] == 4'h0) begin
      char_next = msg_char(bus.msg_sel, bus.char_yx[3:0]);
      if (bus.msg_sel == 2'd0) begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
          if (hit[i]) char_next = dig_char[i];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) char_code_reg <= 8'h00;
    else     char_code_reg <= char_next;
  end

  assign bus.char_code = char_code_reg;
  assign bus.busy      = conv_busy;

endmodule

// File: tb/tb_score_text_gen.sv
// Self-checking bench for score_text_gen: directed scenarios plus random traffic
// compared against a timing/value reference model of the text overlay.
module tb_score_text_gen;

  localparam int SCORE_W = 14;
  localparam int LAT     = SCORE_W + 1;  // load edge to commit edge

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  score_text_gen_if #(.SCORE_W(SCORE_W)) bus ();

  score_text_gen #(
    .SCORE_W    (SCORE_W),
    .NUM_DIGITS (4),
    .DIGIT_COL  (8'h0C),
    .LZ_BLANK   (1'b0)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model state
  int         cyc = 0;
  bit         m_active = 0;
  int         m_end = 0;
  int         m_val = 0;
  bit         m_pend = 0;
  int         m_pend_val = 0;
  int         m_shown = 0;
  logic [7:0] exp_code = 8'h00;

  function automatic int sat(input int v);
    return (v > 9999) ? 9999 : v;
  endfunction

  function automatic logic [7:0] ref_char(input logic [7:0] yx, input logic [1:0] sel, input int val);
    int    col;
    string s;
    byte   c;
    col = int'(yx[3:0]);
    if (yx[7:4] != 4'h0) return 8'h00;
    if (sel == 2'd0 && col >= 12 && col <= 15)
      return 8'h30 + 8'((val / (10 ** (15 - col))) % 10);
    case (sel)
      2'd0:    s = "YOUR SCORE:";
      2'd1:    s = "GAME OVER";
      2'd2:    s = "PRESS START";
      default: s = "";
    endcase
    if (col < s.len()) begin
      c = s[col];
      return (c == " ") ? 8'h00 : 8'(c);
    end
    return 8'h00;
  endfunction

  // Advance one clock: update the model with what the DUT sampled, then settle at negedge.
  task automatic tick();
    bit was_busy;
    @(posedge clk);
    if (rst) begin
      exp_code = 8'h00;
      m_active = 0;
      m_pend   = 0;
      m_shown  = 0;
    end else begin
      exp_code = ref_char(bus.char_yx, bus.msg_sel, m_shown);
      was_busy = m_active;
      if (was_busy && cyc == m_end) begin
        m_shown  = m_val;
        m_active = 0;
      end
      if (bus.score_load && was_busy) begin
        m_pend     = 1;
        m_pend_val = sat(int'(bus.score));
      end else if (!was_busy && (bus.score_load || m_pend)) begin
        m_val    = bus.score_load ? sat(int'(bus.score)) : m_pend_val;
        m_pend   = 0;
        m_active = 1;
        m_end    = cyc + LAT;
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while ((m_active || m_pend) && n < 200) begin
      tick();
      n++;
    end
    checks++;
    if (m_active || m_pend) begin
      failures++;
      $display("FAIL %s_timeout: conversion still pending after %0d cycles, required idle", tag, n);
    end
  endtask

  task automatic test_reset();
    logic [7:0] v;
    rst = 1'b1;
    bus.score_load = 1'b0;
    bus.score = '0;
    bus.msg_sel = 2'd0;
    bus.char_yx = 8'h0C;
    tick();
    tick();
    checks++;
    if (bus.char_code !== 8'h00 || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: code=%h busy=%b required 00/0", bus.char_code, bus.busy);
    end
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      v = 8'h0C + 8'(i);
      bus.char_yx = v;
      tick();
      checks++;
      if (bus.char_code !== 8'h30 || bus.busy !== 1'b0) begin
        failures++;
        $display("FAIL reset_digits col=%h: code=%h busy=%b required 30/0", v, bus.char_code, bus.busy);
      end
      $display("reset col=%h code=%h", v, bus.char_code);
    end
  endtask

  task automatic test_load_1234();
    int         nbusy;
    logic [7:0] want [4];
    want = '{8'h31, 8'h32, 8'h33, 8'h34};
    bus.score = 14'd1234;
    bus.score_load = 1'b1;
    bus.char_yx = 8'h0C;
    tick();
    bus.score_load = 1'b0;
    nbusy = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.busy === 1'b1) nbusy++;
      checks++;
      if (bus.char_code !== exp_code || bus.busy !== m_active) begin
        failures++;
        $display("FAIL load1234_cycle%0d: code=%h busy=%b required %h/%b", i, bus.char_code, bus.busy, exp_code, m_active);
      end
      bus.char_yx = 8'h0C + 8'(i % 4);
      tick();
    end
    checks++;
    if (nbusy != SCORE_W + 1) begin
      failures++;
      $display("FAIL load1234_busy_len: busy cycles=%0d required %0d", nbusy, SCORE_W + 1);
    end
    $display("load 1234 busy_cycles=%0d", nbusy);
    for (int i = 0; i < 4; i++) begin
      bus.char_yx = 8'h0C + 8'(i);
      tick();
      checks++;
      if (bus.char_code !== want[i]) begin
        failures++;
        $display("FAIL load1234_digit%0d: code=%h required %h", i, bus.char_code, want[i]);
      end
    end
  endtask

  task automatic test_saturation();
    int vals [3];
    vals = '{12000, 9999, 10000};
    foreach (vals[k]) begin
      bus.score = 14'(vals[k]);
      bus.score_load = 1'b1;
      tick();
      bus.score_load = 1'b0;
      wait_idle("sat");
      for (int i = 0; i < 4; i++) begin
        bus.char_yx = 8'h0C + 8'(i);
        tick();
        checks++;
        if (bus.char_code !== 8'h39 || bus.char_code !== exp_code) begin
          failures++;
          $display("FAIL sat_%0d_digit%0d: code=%h required 39", vals[k], i, bus.char_code);
        end
      end
      $display("saturation load %0d -> last code=%h", vals[k], bus.char_code);
    end
  endtask

  task automatic test_back_to_back();
    bit         saw6;
    logic [7:0] want [4];
    want = '{8'h30, 8'h30, 8'h30, 8'h37};
    saw6 = 0;
    bus.char_yx = 8'h0F;
    bus.score = 14'd5; bus.score_load = 1'b1; tick();
    bus.score = 14'd6; tick();
    bus.score_load = 1'b0; tick(); tick(); tick();
    bus.score = 14'd7; bus.score_load = 1'b1; tick();
    bus.score_load = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (bus.char_code === 8'h36) saw6 = 1;
      checks++;
      if (bus.char_code !== exp_code || bus.busy !== m_active) begin
        failures++;
        $display("FAIL b2b_cycle%0d: code=%h busy=%b required %h/%b", i, bus.char_code, bus.busy, exp_code, m_active);
      end
      tick();
    end
    checks++;
    if (saw6) begin
      failures++;
      $display("FAIL b2b_overwritten_shown: digit 6 displayed=1 required 0");
    end
    for (int i = 0; i < 4; i++) begin
      bus.char_yx = 8'h0C + 8'(i);
      tick();
      checks++;
      if (bus.char_code !== want[i]) begin
        failures++;
        $display("FAIL b2b_final_digit%0d: code=%h required %h", i, bus.char_code, want[i]);
      end
    end
    $display("back_to_back final 0007 last code=%h", bus.char_code);
  endtask

  task automatic test_commit_load();
    bus.char_yx = 8'h0E;
    bus.score = 14'd42; bus.score_load = 1'b1; tick();
    bus.score_load = 1'b0;
    for (int i = 0; i < SCORE_W; i++) tick();
    // This edge is the COMMIT edge of the 42 conversion.
    bus.score = 14'd77; bus.score_load = 1'b1; tick();
    bus.score_load = 1'b0;
    for (int i = 0; i < 40; i++) begin
      bus.char_yx = 8'h0E + 8'(i % 2);
      checks++;
      if (bus.char_code !== exp_code || bus.busy !== m_active) begin
        failures++;
        $display("FAIL commit_load_cycle%0d: code=%h busy=%b required %h/%b", i, bus.char_code, bus.busy, exp_code, m_active);
      end
      tick();
    end
    bus.char_yx = 8'h0F; tick();
    checks++;
    if (bus.char_code !== 8'h37) begin
      failures++;
      $display("FAIL commit_load_final: code=%h required 37", bus.char_code);
    end
    $display("commit-cycle load 77 last code=%h", bus.char_code);
  endtask

  task automatic test_reset_abort();
    bus.char_yx = 8'h0D;
    bus.score = 14'd999; bus.score_load = 1'b1; tick();
    bus.score_load = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    rst = 1'b1; tick();
    rst = 1'b0;
    checks++;
    if (bus.busy !== 1'b0 || bus.char_code !== 8'h00) begin
      failures++;
      $display("FAIL abort_reset: busy=%b code=%h required 0/00", bus.busy, bus.char_code);
    end
    for (int i = 0; i < 24; i++) begin
      bus.char_yx = 8'h0C + 8'(i % 4);
      tick();
      checks++;
      if (bus.char_code !== 8'h30 || bus.busy !== 1'b0) begin
        failures++;
        $display("FAIL abort_no_commit_cycle%0d: code=%h busy=%b required 30/0", i, bus.char_code, bus.busy);
      end
    end
    $display("reset abort last code=%h busy=%b", bus.char_code, bus.busy);
  endtask

  task automatic test_messages();
    logic [7:0] go [9];
    go = '{8'h47, 8'h41, 8'h4D, 8'h45, 8'h00, 8'h4F, 8'h56, 8'h45, 8'h52};
    bus.msg_sel = 2'd1;
    for (int i = 0; i < 9; i++) begin
      bus.char_yx = 8'(i);
      tick();
      checks++;
      if (bus.char_code !== go[i]) begin
        failures++;
        $display("FAIL msg1_col%0d: code=%h required %h", i, bus.char_code, go[i]);
      end
    end
    bus.char_yx = 8'h09; tick();
    checks++;
    if (bus.char_code !== 8'h00) begin
      failures++;
      $display("FAIL msg1_col9: code=%h required 00", bus.char_code);
    end
    bus.char_yx = 8'h10; tick();
    checks++;
    if (bus.char_code !== 8'h00) begin
      failures++;
      $display("FAIL msg1_row1: code=%h required 00", bus.char_code);
    end
    $display("message 1 sweep done last code=%h", bus.char_code);
    bus.msg_sel = 2'd0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      bus.score_load = ($urandom_range(0, 9) == 0);
      bus.score      = 14'($urandom_range(0, 16383));
      bus.msg_sel    = 2'($urandom_range(0, 3));
      bus.char_yx    = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 255))
                                                   : {4'h0, 4'($urandom_range(0, 15))};
      tick();
      checks++;
      if (bus.char_code !== exp_code || bus.busy !== m_active) begin
        failures++;
        $display("FAIL random_cycle%0d: code=%h busy=%b required %h/%b", i, bus.char_code, bus.busy, exp_code, m_active);
      end
    end
    bus.score_load = 1'b0;
    wait_idle("random");
    $display("random traffic done shown=%0d", m_shown);
  endtask

  initial begin
    test_reset();
    test_load_1234();
    test_saturation();
    test_back_to_back();
    test_commit_load();
    test_reset_abort();
    test_messages();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
